// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Holds the default payload/control widths, the maximum slot count and the
// bit offsets of each field inside the control bundle, plus a popcount helper
// used to derive slot occupancy.
package pipe_pkg;

  localparam int IDEX_DATA_W = 111;
  localparam int IDEX_CTRL_W = 11;
  localparam int MAX_DEPTH   = 4;

  // Control-bundle layout, LSB first.
  localparam int CTRL_ALUCTRL_LSB = 0;
  localparam int CTRL_ALUCTRL_W   = 6;
  localparam int CTRL_ALUSRC_BIT   = 6;
  localparam int CTRL_REGWRITE_BIT = 7;
  localparam int CTRL_MEMTOREG_BIT = 8;
  localparam int CTRL_MEMWRITE_BIT = 9;
  localparam int CTRL_REGDST_BIT   = 10;

  typedef struct packed {
    logic       regDst;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrc;
    logic [5:0] aluCtrl;
  } idexCtrl_t;

  // Number of set bits in a slot-valid vector (0..MAX_DEPTH).
  function automatic logic [2:0] countValid(input logic [MAX_DEPTH-1:0] vldVec);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      cnt = cnt + {2'b00, vldVec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline slot: valid bit, control bundle and payload.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (clears everything)
//   kill                clear valid and control (payload too if CLEAR_DATA=1)
//   hold                keep current contents
//   vldIn/ctrlIn/dataIn contents loaded when neither kill nor hold
//   vldOut/ctrlOut/dataOut current slot contents
// Priority: reset, kill, hold, load. Control is gated by valid on load so a
// slot that holds no instruction never carries non-zero control.
module pipe_stage_slot #(
  parameter int DATA_W     = 111,
  parameter int CTRL_W     = 11,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kill,
  input  logic              hold,
  input  logic              vldIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              vldOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [DATA_W-1:0] dataOut
);

  logic              vld_p0;
  logic [CTRL_W-1:0] ctrl_p0;
  logic [DATA_W-1:0] data_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      data_p0 <= '0;
    end else if (kill) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= '0;
      if (CLEAR_DATA) begin
        data_p0 <= '0;
      end
    end else if (!hold) begin
      vld_p0  <= vldIn;
      ctrl_p0 <= vldIn ? ctrlIn : '0;
      data_p0 <= dataIn;
    end
  end

  assign vldOut  = vld_p0;
  assign ctrlOut = ctrl_p0;
  assign dataOut = data_p0;

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable-depth ID/EX pipeline register with stall and flush.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   stall_i         hold every slot
//   flush_i         kill every slot (wins over stall_i)
//   valid_i, data_i, ctrl_i   incoming instruction
//   valid_o, data_o, ctrl_o   last-slot contents (registered, no input path)
//   occupancy_o     number of slots holding a valid instruction
// DEPTH slots are chained in series; an instruction appears at the outputs
// after DEPTH advancing edges.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = IDEX_DATA_W,
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b0,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [OCC_W-1:0]  occupancy_o
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : gBadDepth
    $error("pipe_stage_reg: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  slotVld;
  logic [CTRL_W-1:0] slotCtrl [DEPTH];
  logic [DATA_W-1:0] slotData [DEPTH];
  logic [MAX_DEPTH-1:0] vldPad;

  for (genvar k = 0; k < DEPTH; k++) begin : gSlot
    logic              vldIn;
    logic [CTRL_W-1:0] ctrlIn;
    logic [DATA_W-1:0] dataIn;

    if (k == 0) begin : gHead
      assign vldIn  = valid_i;
      assign ctrlIn = ctrl_i;
      assign dataIn = data_i;
    end else begin : gChain
      assign vldIn  = slotVld[k-1];
      assign ctrlIn = slotCtrl[k-1];
      assign dataIn = slotData[k-1];
    end

    pipe_stage_slot #(
      .DATA_W     (DATA_W),
      .CTRL_W     (CTRL_W),
      .CLEAR_DATA (CLEAR_DATA)
    ) uSlot (
      .clk     (clk),
      .rst_n   (rst_n),
      .kill    (flush_i),
      .hold    (stall_i),
      .vldIn   (vldIn),
      .ctrlIn  (ctrlIn),
      .dataIn  (dataIn),
      .vldOut  (slotVld[k]),
      .ctrlOut (slotCtrl[k]),
      .dataOut (slotData[k])
    );
  end

  assign valid_o = slotVld[DEPTH-1];
  assign ctrl_o  = slotCtrl[DEPTH-1];
  assign data_o  = slotData[DEPTH-1];

  // Occupancy is a pure function of the slot valid registers.
  assign vldPad      = MAX_DEPTH'(slotVld);
  assign occupancy_o = OCC_W'(countValid(vldPad));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DW = 111;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_i;
  logic          flush_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic [CW-1:0] ctrl_i;

  // DEPTH=3, CLEAR_DATA=0
  logic          v3;
  logic [DW-1:0] d3;
  logic [CW-1:0] c3;
  logic [1:0]    o3;
  // DEPTH=2, CLEAR_DATA=0
  logic          v2;
  logic [DW-1:0] d2;
  logic [CW-1:0] c2;
  logic [1:0]    o2;
  // DEPTH=1, CLEAR_DATA=1
  logic          v1;
  logic [DW-1:0] d1;
  logic [CW-1:0] c1;
  logic [0:0]    o1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(3), .CLEAR_DATA(1'b0)) dut3 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(v3), .data_o(d3), .ctrl_o(c3), .occupancy_o(o3));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(2), .CLEAR_DATA(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(v2), .data_o(d2), .ctrl_o(c2), .occupancy_o(o2));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .DEPTH(1), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .data_i(data_i), .ctrl_i(ctrl_i),
    .valid_o(v1), .data_o(d1), .ctrl_o(c1), .occupancy_o(o1));

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    valid_i = 1'b1; data_i = DW'(32'hDEAD); ctrl_i = 11'h7FF;
    step();
    step();
    total++; if (v3 !== 1'b0 || d3 !== '0 || c3 !== '0 || o3 !== 2'd0) begin
      bad++; $display("FAIL reset_d3: v=%0b d=%0h c=%0h o=%0d required all 0", v3, d3, c3, o3); end
    total++; if (v2 !== 1'b0 || d2 !== '0 || c2 !== '0 || o2 !== 2'd0) begin
      bad++; $display("FAIL reset_d2: v=%0b d=%0h c=%0h o=%0d required all 0", v2, d2, c2, o2); end
    total++; if (v1 !== 1'b0 || d1 !== '0 || c1 !== '0 || o1 !== 1'd0) begin
      bad++; $display("FAIL reset_d1: v=%0b d=%0h c=%0h o=%0d required all 0", v1, d1, c1, o1); end
  endtask

  // data 1..7 on consecutive edges; DEPTH=3 output lags by 3 edges.
  task automatic test_fill();
    logic [1:0] expOcc;
    rst_n = 1'b1; valid_i = 1'b1; ctrl_i = 11'h123;
    for (int i = 1; i <= 7; i++) begin
      data_i = DW'(i);
      step();
      expOcc = (i >= 3) ? 2'd3 : 2'(i);
      total++; if (o3 !== expOcc) begin
        bad++; $display("FAIL fill_occ e%0d: got %0d required %0d", i, o3, expOcc); end
      if (i >= 3) begin
        total++; if (v3 !== 1'b1 || d3 !== DW'(i - 2) || c3 !== 11'h123) begin
          bad++; $display("FAIL fill_out e%0d: v=%0b d=%0h c=%0h required v=1 d=%0h c=123",
                          i, v3, d3, c3, i - 2); end
      end else begin
        total++; if (v3 !== 1'b0 || c3 !== '0) begin
          bad++; $display("FAIL fill_empty e%0d: v=%0b c=%0h required v=0 c=0", i, v3, c3); end
      end
    end
  endtask

  // Pipe holds 7,6,5 (5 at output). Stall 4 edges with changing input.
  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = DW'(32'h100 + i);
      ctrl_i = 11'h0F0;
      step();
      total++; if (v3 !== 1'b1 || d3 !== DW'(5) || c3 !== 11'h123 || o3 !== 2'd3) begin
        bad++; $display("FAIL stall_hold s%0d: v=%0b d=%0h c=%0h o=%0d required v=1 d=5 c=123 o=3",
                        i, v3, d3, c3, o3); end
    end
    stall_i = 1'b0; data_i = DW'(32'h200); ctrl_i = 11'h123;
    step();
    total++; if (d3 !== DW'(6)) begin
      bad++; $display("FAIL stall_resume1: got %0h required 6", d3); end
    step();
    total++; if (d3 !== DW'(7)) begin
      bad++; $display("FAIL stall_resume2: got %0h required 7", d3); end
    step();
    total++; if (d3 !== DW'(32'h200)) begin
      bad++; $display("FAIL stall_resume3: got %0h required 200", d3); end
  endtask

  // DEPTH=2 full pipe, flush and stall together; payload kept.
  task automatic test_flush_stall();
    valid_i = 1'b1; ctrl_i = 11'h055;
    data_i = DW'(32'hA1); step();
    data_i = DW'(32'hA2); step();
    total++; if (v2 !== 1'b1 || d2 !== DW'(32'hA1) || c2 !== 11'h055 || o2 !== 2'd2) begin
      bad++; $display("FAIL fs_prefill: v=%0b d=%0h c=%0h o=%0d required v=1 d=a1 c=55 o=2",
                      v2, d2, c2, o2); end
    flush_i = 1'b1; stall_i = 1'b1; data_i = DW'(32'hFF);
    step();
    total++; if (v2 !== 1'b0 || c2 !== '0 || d2 !== DW'(32'hA1) || o2 !== 2'd0) begin
      bad++; $display("FAIL fs_flush_d2: v=%0b d=%0h c=%0h o=%0d required v=0 d=a1 c=0 o=0",
                      v2, d2, c2, o2); end
    total++; if (v1 !== 1'b0 || c1 !== '0 || d1 !== '0 || o1 !== 1'd0) begin
      bad++; $display("FAIL fs_flush_d1: v=%0b d=%0h c=%0h o=%0d required all 0", v1, d1, c1, o1); end
    flush_i = 1'b0; stall_i = 1'b0;
  endtask

  // DEPTH=1 CLEAR_DATA=1: flush zeroes payload too.
  task automatic test_flush_clear();
    valid_i = 1'b1; ctrl_i = 11'h7FF; data_i = DW'(32'h5);
    step();
    total++; if (v1 !== 1'b1 || d1 !== DW'(5) || c1 !== 11'h7FF || o1 !== 1'd1) begin
      bad++; $display("FAIL fc_load: v=%0b d=%0h c=%0h o=%0d required v=1 d=5 c=7ff o=1",
                      v1, d1, c1, o1); end
    flush_i = 1'b1; data_i = DW'(32'hABC);
    step();
    total++; if (v1 !== 1'b0 || d1 !== '0 || c1 !== '0 || o1 !== 1'd0) begin
      bad++; $display("FAIL fc_flush: v=%0b d=%0h c=%0h o=%0d required all 0", v1, d1, c1, o1); end
    flush_i = 1'b0;
  endtask

  // valid 1,0,1 with ctrl 7FF; control gated by valid, payload passes.
  task automatic test_valid_toggle();
    logic          vt [6];
    logic [DW-1:0] dt [6];
    logic [CW-1:0] expC;
    vt = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    dt = '{DW'(32'h11), DW'(32'h22), DW'(32'h33), DW'(0), DW'(0), DW'(0)};
    ctrl_i = 11'h7FF;
    for (int e = 1; e <= 6; e++) begin
      valid_i = vt[e-1]; data_i = dt[e-1];
      step();
      expC = vt[e-1] ? 11'h7FF : 11'h000;
      total++; if (c1 !== expC || v1 !== vt[e-1]) begin
        bad++; $display("FAIL vt_d1 e%0d: c=%0h v=%0b required c=%0h v=%0b", e, c1, v1, expC, vt[e-1]); end
      if (e >= 3) begin
        expC = vt[e-3] ? 11'h7FF : 11'h000;
        total++; if (c3 !== expC || v3 !== vt[e-3] || d3 !== dt[e-3]) begin
          bad++; $display("FAIL vt_d3 e%0d: c=%0h v=%0b d=%0h required c=%0h v=%0b d=%0h",
                          e, c3, v3, d3, expC, vt[e-3], dt[e-3]); end
      end
    end
  endtask

  // Reset while stalled with a full pipe, then latency with a stall in between.
  task automatic test_reset_mid_stall();
    valid_i = 1'b1; ctrl_i = 11'h00F;
    for (int i = 0; i < 3; i++) begin
      data_i = DW'(32'h40 + i); step();
    end
    stall_i = 1'b1; step();
    rst_n = 1'b0; step();
    total++; if (v3 !== 1'b0 || d3 !== '0 || c3 !== '0 || o3 !== 2'd0) begin
      bad++; $display("FAIL rms_d3: v=%0b d=%0h c=%0h o=%0d required all 0", v3, d3, c3, o3); end
    total++; if (v2 !== 1'b0 || d2 !== '0 || c2 !== '0 || o2 !== 2'd0) begin
      bad++; $display("FAIL rms_d2: v=%0b d=%0h c=%0h o=%0d required all 0", v2, d2, c2, o2); end
    rst_n = 1'b1; stall_i = 1'b0;
    valid_i = 1'b1; data_i = DW'(32'h77); ctrl_i = 11'h003;
    step();
    total++; if (v1 !== 1'b1 || d1 !== DW'(32'h77) || c1 !== 11'h003) begin
      bad++; $display("FAIL rms_lat_d1: v=%0b d=%0h c=%0h required v=1 d=77 c=3", v1, d1, c1); end
    valid_i = 1'b0; data_i = '0; ctrl_i = '0;
    stall_i = 1'b1; step();
    stall_i = 1'b0; step();
    total++; if (v3 !== 1'b0 || o3 !== 2'd1) begin
      bad++; $display("FAIL rms_lat_early: v=%0b o=%0d required v=0 o=1", v3, o3); end
    step();
    total++; if (v3 !== 1'b1 || d3 !== DW'(32'h77) || c3 !== 11'h003 || o3 !== 2'd1) begin
      bad++; $display("FAIL rms_lat_d3: v=%0b d=%0h c=%0h o=%0d required v=1 d=77 c=3 o=1",
                      v3, d3, c3, o3); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_flush_stall();
    test_flush_clear();
    test_valid_toggle();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
